// File: rtl/r_cpu_pkg.sv
// r_cpu_pkg: shared definitions for the R-type instruction loader.
//   - ALU operation encodings (ALU_AND..ALU_SLL) and matching MIPS funct codes
//   - R-format opcode constant
//   - loader FSM state enum; ST_PAD exists only when R_LOADER_NOP_PAD_EN is defined
//   - alu_funct(): maps an ALU operation to its funct field
package r_cpu_pkg;

  localparam logic [5:0] R_OPCODE = 6'b000000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_SLL = 6'h00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
`ifdef R_LOADER_NOP_PAD_EN
    ST_PAD     = 3'd2,
`endif
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } ldr_state_e;

  function automatic logic [5:0] alu_funct(input logic [2:0] op);
    logic [5:0] f;
    case (op)
      ALU_AND: f = FUNCT_AND;
      ALU_OR:  f = FUNCT_OR;
      ALU_XOR: f = FUNCT_XOR;
      ALU_NOR: f = FUNCT_NOR;
      ALU_ADD: f = FUNCT_ADD;
      ALU_SUB: f = FUNCT_SUB;
      ALU_SLT: f = FUNCT_SLT;
      ALU_SLL: f = FUNCT_SLL;
      default: f = FUNCT_SLL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/r_inst_loader_if.sv
// r_inst_loader_if: valid/ready stream carrying R-type instruction fields.
//   in_valid, alu_op, rs, rt, rd, shamt, last : source -> loader
//   in_ready                                  : loader -> source
// Modports: master (field source), slave (loader).
interface r_inst_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] alu_op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] shamt;
  logic       last;

  modport master (output in_valid, alu_op, rs, rt, rd, shamt, last, input in_ready);
  modport slave  (input in_valid, alu_op, rs, rt, rd, shamt, last, output in_ready);
endinterface

// File: rtl/r_inst_encode.sv
// r_inst_encode: combinational MIPS R-format encoder.
//   alu_op_i/rs_i/rt_i/rd_i/shamt_i in, word_o = {opcode, rs, rt, rd, shamt, funct} out.
//   SLL keeps shamt and zeroes rs; every other op zeroes shamt.
module r_inst_encode
  import r_cpu_pkg::*;
(
  input  logic [2:0]  alu_op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] word_o
);
  logic [4:0] rs_f;
  logic [4:0] sh_f;

  // Field masking for the shift-versus-register forms, then packing.
  always_comb begin
    if (alu_op_i == ALU_SLL) begin
      rs_f = 5'd0;
      sh_f = shamt_i;
    end else begin
      rs_f = rs_i;
      sh_f = 5'd0;
    end
    word_o = {R_OPCODE, rs_f, rt_i, rd_i, sh_f, alu_funct(alu_op_i)};
  end
endmodule

// File: rtl/r_inst_loader.sv
// r_inst_loader: streams R-type instruction fields into instruction memory and
// then releases the CPU reset after RELEASE_DLY cycles.
//   clk, rst (sync, active-high), start (session pulse)
//   in_if    : r_inst_loader_if.slave instruction field stream
//   im_we/im_addr/im_wdata : registered instruction memory write port
//   cpu_rst  : CPU reset, high except in DONE
//   done, overflow, count  : session status
// Optional macro R_LOADER_NOP_PAD_EN: append up to PAD_NOPS zero (NOP) words
// after the last instruction, stopping at address DEPTH-1.
module r_inst_loader
  import r_cpu_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int DEPTH       = 64,
  parameter int RELEASE_DLY = 4,
  parameter int PAD_NOPS    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  r_inst_loader_if.slave    in_if,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   count
);
  localparam int DLY_W = (RELEASE_DLY < 2) ? 1 : $clog2(RELEASE_DLY + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DLY_W-1:0]  DLY_INIT  = DLY_W'(RELEASE_DLY);

  ldr_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;     // next word address to write
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              cpu_rst_q, done_q;
  logic [31:0]       enc_word;
  logic              xfer;

`ifdef R_LOADER_NOP_PAD_EN
  localparam int PAD_W = (PAD_NOPS < 2) ? 1 : $clog2(PAD_NOPS + 1);
  logic [PAD_W-1:0] pad_q, pad_d;
`endif

  r_inst_encode u_enc (
    .alu_op_i (in_if.alu_op),
    .rs_i     (in_if.rs),
    .rt_i     (in_if.rt),
    .rd_i     (in_if.rd),
    .shamt_i  (in_if.shamt),
    .word_o   (enc_word)
  );

  assign in_if.in_ready = (state_q == ST_LOAD);
  assign xfer           = in_if.in_valid && (state_q == ST_LOAD);

  // Next-state, write-port and counter logic.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    dly_d   = dly_q;
`ifdef R_LOADER_NOP_PAD_EN
    pad_d   = pad_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          wptr_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = wptr_q;
          wdata_d = enc_word;
          wptr_d  = wptr_q + 1'b1;
          count_d = count_q + 1'b1;
          if (in_if.last) begin
`ifdef R_LOADER_NOP_PAD_EN
            // No room left (or nothing to pad): skip straight to release.
            if ((wptr_q == LAST_ADDR) || (PAD_NOPS == 0)) begin
              state_d = ST_RELEASE;
              dly_d   = DLY_INIT;
            end else begin
              state_d = ST_PAD;
              pad_d   = PAD_W'(PAD_NOPS);
            end
`else
            state_d = ST_RELEASE;
            dly_d   = DLY_INIT;
`endif
          end else if (wptr_q == LAST_ADDR) begin
            ovf_d   = 1'b1;
            state_d = ST_RELEASE;
            dly_d   = DLY_INIT;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
`ifdef R_LOADER_NOP_PAD_EN
      ST_PAD: begin
        we_d    = 1'b1;
        addr_d  = wptr_q;
        wdata_d = 32'h0000_0000;
        wptr_d  = wptr_q + 1'b1;
        pad_d   = pad_q - 1'b1;
        if ((pad_q == PAD_W'(1)) || (wptr_q == LAST_ADDR)) begin
          state_d = ST_RELEASE;
          dly_d   = DLY_INIT;
        end else begin
          state_d = ST_PAD;
        end
      end
`endif
      ST_RELEASE: begin
        if (dly_q == '0) begin
          state_d = ST_DONE;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; cpu_rst/done are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0000_0000;
      wptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      dly_q     <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
`ifdef R_LOADER_NOP_PAD_EN
      pad_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      dly_q     <= dly_d;
      cpu_rst_q <= (state_d != ST_DONE);
      done_q    <= (state_d == ST_DONE);
`ifdef R_LOADER_NOP_PAD_EN
      pad_q     <= pad_d;
`endif
    end
  end

  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign count    = count_q;
endmodule

// File: tb/tb_r_inst_loader.sv
module tb_r_inst_loader;
  localparam int ADDR_W      = 4;
  localparam int DEPTH       = 8;
  localparam int RELEASE_DLY = 3;
  localparam int PAD_NOPS    = 2;

  typedef struct {
    bit       v;
    bit [2:0] op;
    bit [4:0] rs, rt, rd, sh;
    bit       last;
  } beat_t;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst, done, overflow;
  logic [ADDR_W:0]   count;

  int n_cmp = 0;
  int n_err = 0;
  exp_t  exp_q[$];
  beat_t beats[$];
  int funct_tab [8] = '{36, 37, 38, 39, 32, 34, 42, 0};

  r_inst_loader_if ifc ();

  r_inst_loader #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RELEASE_DLY(RELEASE_DLY), .PAD_NOPS(PAD_NOPS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_if(ifc),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rst(cpu_rst), .done(done), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference encoding from the field layout, plain arithmetic.
  function automatic logic [31:0] model_word(beat_t b);
    int rsv = (b.op == 3'd7) ? 0 : int'(b.rs);
    int shv = (b.op == 3'd7) ? int'(b.sh) : 0;
    return 32'(rsv * (1 << 21) + int'(b.rt) * (1 << 16) + int'(b.rd) * (1 << 11)
               + shv * 64 + funct_tab[b.op]);
  endfunction

  function automatic beat_t mk(bit v, int op, int rs, int rt, int rd, int sh, bit last);
    beat_t b;
    b.v = v; b.op = 3'(op); b.rs = 5'(rs); b.rt = 5'(rt); b.rd = 5'(rd); b.sh = 5'(sh);
    b.last = last;
    return b;
  endfunction

  // Monitor: every write the DUT presents is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (im_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got write addr %0d data %08h, required none", im_addr, im_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("im_addr", 32'(im_addr), 32'(e.addr));
          chk("im_wdata", im_wdata, e.data);
        end
      end
    end
  end

  task automatic check_reset_state(string tag);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    chk({tag, "_in_ready"}, 32'(ifc.in_ready), 32'd0);
    chk({tag, "_im_we"}, 32'(im_we), 32'd0);
    chk({tag, "_im_addr"}, 32'(im_addr), 32'd0);
    chk({tag, "_im_wdata"}, im_wdata, 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
  endtask

  // Runs one load session over 'beats'; rst_at >= 0 asserts rst on that beat.
  task automatic session(input int rst_at);
    int  acc = 0;
    bit  fin = 0;
    bit  ovf = 0;
    int  since = -1;
    int  pad = 0;
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("load_done", 32'(done), 32'd0);
    chk("load_count", 32'(count), 32'd0);
    chk("load_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < beats.size(); i++) begin
      chk("in_ready", 32'(ifc.in_ready), 32'(!fin));
      ifc.in_valid = beats[i].v;
      ifc.alu_op   = beats[i].op;
      ifc.rs       = beats[i].rs;
      ifc.rt       = beats[i].rt;
      ifc.rd       = beats[i].rd;
      ifc.shamt    = beats[i].sh;
      ifc.last     = beats[i].last;
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ifc.in_valid = 1'b0;
        check_reset_state("midrst");
        chk("midrst_pending", 32'(exp_q.size()), 32'd0);
        return;
      end
      if (beats[i].v && !fin) begin
        e.addr = acc;
        e.data = model_word(beats[i]);
        exp_q.push_back(e);
        acc++;
        if (beats[i].last) begin
          fin = 1; since = -1;
        end else if (acc == DEPTH) begin
          fin = 1; ovf = 1; since = -1;
        end
      end
      @(negedge clk);
      if (fin) since++;
    end
    ifc.in_valid = 1'b0;
`ifdef R_LOADER_NOP_PAD_EN
    if (!ovf) begin
      pad = (PAD_NOPS < DEPTH - acc) ? PAD_NOPS : DEPTH - acc;
      for (int p = 0; p < pad; p++) begin
        e.addr = acc + p;
        e.data = 32'h0;
        exp_q.push_back(e);
      end
    end
`endif
    while (done !== 1'b1 && since < 200) begin
      chk("cpu_rst_held", 32'(cpu_rst), 32'd1);
      @(negedge clk);
      since++;
    end
    chk("done_latency", 32'(since), 32'(pad + RELEASE_DLY + 1));
    chk("done_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("done_count", 32'(count), 32'(acc));
    chk("done_overflow", 32'(overflow), 32'(ovf));
    chk("done_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("writes_pending", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_count", 32'(count), 32'(acc));
  endtask

  task automatic gen_random();
    int n = ($urandom_range(4, 0) == 0) ? DEPTH + 1 : int'($urandom_range(DEPTH, 1));
    bit ovf = (n > DEPTH);
    int v = 0;
    beat_t b;
    beats.delete();
    while (v < n) begin
      b = mk($urandom_range(3, 0) != 0, int'($urandom_range(7, 0)), int'($urandom_range(31, 0)),
             int'($urandom_range(31, 0)), int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
             1'b0);
      if (b.v) begin
        v++;
        b.last = (v == n) && !ovf;
      end else begin
        b.last = 1'($urandom_range(1, 0));
      end
      beats.push_back(b);
    end
  endtask

  initial begin
    ifc.in_valid = 1'b0; ifc.alu_op = 3'd0; ifc.rs = 5'd0; ifc.rt = 5'd0;
    ifc.rd = 5'd0; ifc.shamt = 5'd0; ifc.last = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("idle");

    // ADD $3,$1,$2 as a one-word program.
    beats.delete();
    beats.push_back(mk(1, 4, 1, 2, 3, 0, 1));
    session(-1);
    // SUB then SLL back to back (from DONE).
    beats.delete();
    beats.push_back(mk(1, 5, 4, 5, 6, 0, 0));
    beats.push_back(mk(1, 7, 9, 1, 2, 4, 1));
    session(-1);
    // Valid toggling 1,0,1.
    beats.delete();
    beats.push_back(mk(1, 0, 7, 8, 9, 3, 0));
    beats.push_back(mk(0, 1, 1, 1, 1, 1, 1));
    beats.push_back(mk(1, 6, 10, 11, 12, 5, 1));
    session(-1);
    // Overflow: DEPTH+1 words without last.
    beats.delete();
    for (int i = 0; i <= DEPTH; i++) beats.push_back(mk(1, i % 8, i, i + 1, i + 2, i, 0));
    session(-1);
    // Reset after two words, with a third transfer in flight.
    beats.delete();
    for (int i = 0; i < 3; i++) beats.push_back(mk(1, 2, i, i, i, 0, 0));
    session(2);
    // Reload from IDLE.
    beats.delete();
    beats.push_back(mk(1, 3, 31, 30, 29, 7, 1));
    session(-1);

    for (int s = 0; s < 30; s++) begin
      gen_random();
      session(-1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/r_inst_loader.md
Name: r_inst_loader

Overview:
- Writer-side counterpart to the R-type CPU instruction fetch path.
- Accepts R-type instruction fields over a valid/ready stream and encodes each into a 32-bit MIPS R-format word.
- Writes encoded words into the instruction memory at incrementing word addresses, holding the CPU in reset while loading.
- Releases the CPU reset after a programmable delay, so the CPU starts fetching at PC 0 from a freshly loaded program.

Parameters:
- ADDR_W, 6, instruction memory word-address width.
- DEPTH, 64, instruction memory words; must be ≤ 2^ADDR_W.
- RELEASE_DLY, 4, cycles cpu_rst stays high after the last write.
- PAD_NOPS, 2, trailing NOP words written when R_LOADER_NOP_PAD_EN is defined.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load session.
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  loader can accept fields this cycle.
- alu_op  input  3  ALU operation, selects funct.
- rs  input  5  source register 1.
- rt  input  5  source register 2.
- rd  input  5  destination register.
- shamt  input  5  shift amount; used only for SLL.
- last  input  1  marks final instruction of the program.
- im_we  output  1  instruction memory write enable.
- im_addr  output  ADDR_W  word address.
- im_wdata  output  32  encoded instruction.
- cpu_rst  output  1  CPU reset, active-high.
- done  output  1  load complete and CPU released.
- overflow  output  1  program exceeded DEPTH.
- count  output  ADDR_W+1  instructions written this session.

Behaviour:
- Reset values:
  - state=IDLE, cpu_rst=1.
  - in_ready=0, im_we=0, im_addr=0, im_wdata=0.
  - done=0, overflow=0, count=0.
- Encoding:
  - {6'b0, rs, rt, rd, shamt', funct}, where shamt' = shamt for SLL and 0 otherwise.
  - For SLL, the rs field is forced to 0.
- alu_op to funct mapping:
  - 000 AND 0x24
  - 001 OR 0x25
  - 010 XOR 0x26
  - 011 NOR 0x27
  - 100 ADD 0x20
  - 101 SUB 0x22
  - 110 SLT 0x2A
  - 111 SLL 0x00
- Handshake:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = (state==LOAD).
  - Throughput is one word per cycle.
  - Fields sampled at transfer edge t appear as im_we=1 with registered im_addr/im_wdata during cycle t+1.
  - im_addr increments after each write.
  - count increments on each transfer.
- IDLE:
  - cpu_rst=1, done=0.
  - start goes to LOAD; im_addr, count and overflow are cleared.
- LOAD:
  - A transfer with last=1 goes to PAD if the feature is enabled, otherwise to RELEASE.
  - A transfer at word DEPTH-1 with last=0 sets overflow=1 and goes to RELEASE; PAD is skipped.
  - start is ignored in LOAD.
- RELEASE:
  - cpu_rst=1, im_we=0.
  - A down-counter runs RELEASE_DLY cycles, then goes to DONE.
  - RELEASE_DLY=0 goes to DONE on the next cycle.
- DONE:
  - cpu_rst=0, done=1; count and overflow are held.
  - start returns to LOAD: cpu_rst=1 and done=0 from the next cycle, address restarts at 0.
- rst mid-session (any state):
  - Returns to IDLE with reset values on the next edge.
  - Any in-flight write is dropped; im_we=0.
- Before start, cpu_rst is held high, so the CPU never runs on a partial program.

Optional Feature:
- Macro: R_LOADER_NOP_PAD_EN.
- Defined:
  - PAD state writes PAD_NOPS words of 32'h00000000 (SLL $0,$0,0) after the last instruction, one per cycle.
  - in_ready=0 during PAD.
  - Padding stops early at address DEPTH-1 without setting overflow; count excludes pad words.
  - Then goes to RELEASE.
- Undefined: the PAD state and PAD_NOPS logic are absent; a last transfer goes directly to RELEASE.

Decomposition:
- Shared package r_cpu_pkg holds:
  - ALU_OP encodings: ALU_AND..ALU_SLL.
  - FUNCT_* constants.
  - Opcode R_OPCODE=6'b0.
  - Loader state enum.
- One sub-module: r_inst_encode, purely combinational; alu_op/rs/rt/rd/shamt in, 32-bit word out.
- The top holds the FSM, counters and output registers.

Test Plan:
- ADD rs=1 rt=2 rd=3 with last=1 → im_we cycle with im_addr=0, im_wdata=0x00221820; count=1; done rises RELEASE_DLY+1 cycles later; cpu_rst falls at the same edge.
- Back-to-back SUB rs=4 rt=5 rd=6 then SLL rd=2 rt=1 shamt=4 (last) → addr0=0x00853022, addr1=0x00011100, consecutive cycles.
- in_valid toggled 1,0,1 with last on the third beat → exactly 2 writes; no write on the idle cycle.
- DEPTH=4, stream 5 words with no last → 4 writes to addrs 0..3; in_ready low after the 4th transfer; overflow=1; count=4; done=1.
- rst asserted during LOAD after 2 words → next cycle state=IDLE, cpu_rst=1, count=0, im_we=0; start then reloads from addr 0.
- With R_LOADER_NOP_PAD_EN, one ADD (last) → addr0 holds the ADD, addr1 and addr2 hold 0x00000000; count=1.
